arith_pipe: RTL and testbench
=============================

ARITH_PIPE -- requirements
Module: arith_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 Parameter OP_W, default 2, opcode width; fixed at 2, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_value_a  input  WIDTH  operand A, unsigned.
REQ-006 i_value_b  input  WIDTH  operand B, unsigned.
REQ-007 i_op  input  2  operation select: 0 ADD, 1 SUB, 2 MUL, 3 MAC.
REQ-008 i_valid  input  1  upstream offers operands and opcode this cycle.
REQ-009 o_ready  output  1  block accepts operands this cycle.
REQ-010 i_acc_clr  input  1  synchronous accumulator clear.
REQ-011 o_result  output  2*WIDTH  registered result.
REQ-012 o_valid  output  1  o_result holds a valid result.
REQ-013 i_ready  input  1  downstream accepts the result.
REQ-014 o_sat  output  1  result was clamped; constant 0 when saturation is compiled out.

Function
REQ-015 Input transfer occurs when i_valid and o_ready are both high; output transfer occurs when o_valid and i_ready are both high.
REQ-016 The block is a 2-stage pipeline: stage 1 registers operands and opcode, stage 2 computes and registers o_result.
REQ-017 The pipeline advance enable is en = !o_valid || i_ready, o_ready equals en, and both stages hold when en is low.
REQ-018 Latency is exactly 2 cycles from input transfer to o_valid when i_ready is held high; throughput is 1 result per cycle.
REQ-019 ADD result is a+b zero-extended to 2*WIDTH, with the carry in bit WIDTH.
REQ-020 SUB result is (a-b) mod 2^(2*WIDTH) when wrapping; for example 2-10 at WIDTH 8 gives 0xFFF8.
REQ-021 MUL result is the full unsigned product a*b in 2*WIDTH bits; it never overflows.
REQ-022 MAC sets acc = acc + a*b, wrapping mod 2^(2*WIDTH), when the op moves from stage 1 to stage 2; o_result equals the new acc.
REQ-023 The accumulator acc is 2*WIDTH bits and changes only on a MAC advance or on i_acc_clr.
REQ-024 When i_acc_clr is high and no MAC advances in the same cycle, acc becomes 0 next cycle.
REQ-025 When i_acc_clr coincides with a MAC advance, the clear is applied first: acc and o_result become a*b.
REQ-026 When stalled (en low), o_result, o_valid, o_sat, acc and stage-1 contents remain stable; i_acc_clr is still honoured.
REQ-027 Stage-1 bubbles (no input transfer) propagate as o_valid=0 on advance, and do not change acc.
REQ-028 ADD, SUB and MUL leave acc unchanged.

Reset
REQ-029 Asserting reset_n low immediately clears o_valid, o_result, o_sat, acc and the stage-1 valid bit, regardless of clk.
REQ-030 While in reset and in the first cycle after reset, o_ready reads 1.
REQ-031 Reset asserted mid-operation discards all in-flight operations; no result for them is ever presented.

Configuration
REQ-032 Macro ARITH_PIPE_SAT_EN controls saturation.
REQ-033 With ARITH_PIPE_SAT_EN defined, a SUB with b>a returns 0 with o_sat=1, and a MAC whose sum exceeds 2^(2*WIDTH)-1 clamps acc and o_result to all-ones with o_sat=1.
REQ-034 With ARITH_PIPE_SAT_EN defined, o_sat is 0 for all other results, and o_sat is registered with o_result.
REQ-035 Without ARITH_PIPE_SAT_EN, SUB and MAC wrap as in REQ-020 and REQ-022, and o_sat is tied to 0.

Verification
REQ-036 WIDTH=8, i_ready=1: a=10, b=2 issued as ADD, SUB, MUL on consecutive cycles -> o_result 12, 8, 20 on consecutive cycles, each 2 cycles after its issue.
REQ-037 WIDTH=8: SUB a=2, b=10 -> 0xFFF8 with o_sat=0 when wrapping; 0x0000 with o_sat=1 when ARITH_PIPE_SAT_EN is defined.
REQ-038 MAC sequence (3,4), (5,6), then i_acc_clr together with MAC (2,2) -> o_result 12, 42, 4.
REQ-039 i_ready held low for 3 cycles with 2 ops in flight -> o_ready=0, o_result stable; on release both results appear in order with no loss or duplication.
REQ-040 WIDTH=8, saturation defined: acc at 0xFFF0, then MAC (255,255) -> o_result 0xFFFF with o_sat=1.
REQ-041 reset_n pulsed low asynchronously mid-stream -> o_valid falls immediately, acc is 0, and no stale result appears after release.

Source files
------------

// File: rtl/arith_pipe.sv
// arith_pipe: two-stage ADD/SUB/MUL/MAC pipeline with valid/ready handshakes on both sides.
// Define ARITH_PIPE_SAT_EN to clamp SUB underflow and MAC overflow; o_sat flags a clamped result.
module arith_pipe #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     i_value_a,
    input  logic [WIDTH-1:0]     i_value_b,
    input  logic [OP_W-1:0]      i_op,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_acc_clr,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sat
);

    localparam int RW = 2 * WIDTH;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MAC = OP_W'(3);

    logic              en;
    logic              advance;
    logic              mac_adv;

    logic              s1_valid;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [OP_W-1:0]   s1_op;

    logic [RW-1:0]     acc;
    logic [RW-1:0]     acc_base;
    logic [RW-1:0]     a_ext;
    logic [RW-1:0]     b_ext;
    logic [RW-1:0]     prod;
    logic [RW-1:0]     res_next;

    // Both stages move together; a full output register blocks everything behind it.
    assign en      = !o_valid || i_ready;
    assign o_ready = en;
    assign advance = en && s1_valid;
    assign mac_adv = advance && (s1_op == OP_MAC);

    assign a_ext    = RW'(s1_a);
    assign b_ext    = RW'(s1_b);
    assign prod     = a_ext * b_ext;
    // A clear coinciding with a MAC advance wipes acc before the product is added.
    assign acc_base = i_acc_clr ? '0 : acc;

`ifdef ARITH_PIPE_SAT_EN
    logic [RW:0] mac_sum;
    logic        sat_next;

    assign mac_sum = {1'b0, acc_base} + {1'b0, prod};

    always_comb begin
        res_next = '0;
        sat_next = 1'b0;
        case (s1_op)
            OP_ADD: res_next = a_ext + b_ext;
            OP_SUB: begin
                if (s1_b > s1_a) begin
                    sat_next = 1'b1;
                end else begin
                    res_next = a_ext - b_ext;
                end
            end
            OP_MUL: res_next = prod;
            default: begin
                if (mac_sum[RW]) begin
                    res_next = '1;
                    sat_next = 1'b1;
                end else begin
                    res_next = mac_sum[RW-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_sat <= 1'b0;
        end else if (advance) begin
            o_sat <= sat_next;
        end
    end
`else
    logic [RW-1:0] mac_sum;

    assign mac_sum = acc_base + prod;

    always_comb begin
        res_next = '0;
        case (s1_op)
            OP_ADD:  res_next = a_ext + b_ext;
            OP_SUB:  res_next = a_ext - b_ext;
            OP_MUL:  res_next = prod;
            default: res_next = mac_sum;
        endcase
    end

    assign o_sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_a  <= i_value_a;
                s1_b  <= i_value_b;
                s1_op <= i_op;
            end
        end
    end

    // Bubbles clear o_valid but leave the last result in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid  <= 1'b0;
            o_result <= '0;
        end else if (en) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_result <= res_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (mac_adv) begin
            acc <= res_next;
        end else if (i_acc_clr) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_arith_pipe.sv
// Self-checking bench for arith_pipe (WIDTH=8): scoreboard of expected {sat,result} values
// filled on each input transfer and consumed on each output transfer.
module tb_arith_pipe;

    localparam int W = 8;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_MAC = 2'd3;

    logic            clk;
    logic            reset_n;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [1:0]      op;
    logic            vld;
    logic            ready;
    logic            clr;
    logic [2*W-1:0]  res;
    logic            res_valid;
    logic            rdy;
    logic            sat;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q[$];
    int          iss_q[$];
    logic [15:0] model_acc;

    arith_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_value_a (a),
        .i_value_b (b),
        .i_op      (op),
        .i_valid   (vld),
        .o_ready   (ready),
        .i_acc_clr (clr),
        .o_result  (res),
        .o_valid   (res_valid),
        .i_ready   (rdy),
        .o_sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic; returns {sat, result} and tracks the accumulator for MAC.
    function automatic logic [16:0] model(input logic [1:0] m_op, input logic [7:0] m_a,
                                          input logic [7:0] m_b, input logic m_clr);
        logic [16:0] s;
        logic [15:0] base;
        case (m_op)
            OP_ADD: return {1'b0, 16'(m_a) + 16'(m_b)};
            OP_SUB: begin
`ifdef ARITH_PIPE_SAT_EN
                if (m_b > m_a) return {1'b1, 16'h0000};
`endif
                return {1'b0, 16'(m_a) - 16'(m_b)};
            end
            OP_MUL: return {1'b0, 16'(m_a) * 16'(m_b)};
            default: begin
                base = m_clr ? 16'h0000 : model_acc;
                s = 17'(base) + 17'(16'(m_a) * 16'(m_b));
`ifdef ARITH_PIPE_SAT_EN
                if (s[16]) begin
                    model_acc = 16'hFFFF;
                    return {1'b1, 16'hFFFF};
                end
`endif
                model_acc = s[15:0];
                return {1'b0, s[15:0]};
            end
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        a = '0; b = '0; op = OP_ADD; vld = 1'b0; clr = 1'b0; rdy = 1'b1;
        model_acc = 16'h0000;
        #2;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_in_reset: got %b, required 1", ready); end
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_in_reset: got %b, required 0", res_valid); end
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b, required 1", ready); end
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_after: got %b, required 0", res_valid); end
        checks++;
        if (res !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h, required 0000", res); end
        checks++;
        if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b, required 0", sat); end
    endtask

    // ADD, SUB, MUL of (10,2) back to back; each result two cycles after its issue.
    task automatic test_basic();
        logic [16:0] e;
        int iss;
        for (int cyc = 0; cyc < 7; cyc++) begin
            vld = (cyc < 3); op = 2'(cyc); a = 8'd10; b = 8'd2; clr = 1'b0; rdy = 1'b1;
            @(negedge clk);
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    iss = iss_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL basic_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                    checks++;
                    if (cyc != iss + 2) begin
                        errors++; $display("FAIL basic_latency: got %0d cycles, required 2", cyc - iss);
                    end
                end
            end
            if (vld && ready) begin
                exp_q.push_back(model(op, a, b, 1'b0));
                iss_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete(); iss_q.delete();
    endtask

    // SUB underflow, equal operands, full wrap, and ADD carry-out.
    task automatic test_sub_boundary();
        logic [7:0] av[4] = '{8'd2, 8'd10, 8'd0, 8'd255};
        logic [7:0] bv[4] = '{8'd10, 8'd10, 8'd255, 8'd255};
        logic [1:0] ov[4] = '{OP_SUB, OP_SUB, OP_SUB, OP_ADD};
        logic [16:0] e;
        for (int cyc = 0; cyc < 8; cyc++) begin
            vld = (cyc < 4); clr = 1'b0; rdy = 1'b1;
            if (cyc < 4) begin a = av[cyc]; b = bv[cyc]; op = ov[cyc]; end
            @(negedge clk);
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sub_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL sub_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (vld && ready) exp_q.push_back(model(op, a, b, 1'b0));
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sub_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // MAC (3,4),(5,6),(2,2); clear arrives as (2,2) advances; ADD leaves acc alone.
    task automatic test_mac_clear();
        logic [7:0] av[7] = '{8'd0, 8'd3, 8'd5, 8'd2, 8'd0, 8'd1, 8'd1};
        logic [7:0] bv[7] = '{8'd0, 8'd4, 8'd6, 8'd2, 8'd0, 8'd1, 8'd1};
        logic [1:0] ov[7] = '{OP_MAC, OP_MAC, OP_MAC, OP_MAC, OP_MAC, OP_ADD, OP_MAC};
        logic       vv[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [16:0] e;
        for (int cyc = 0; cyc < 11; cyc++) begin
            rdy = 1'b1;
            clr = (cyc == 0) || (cyc == 4);
            vld = (cyc < 7) ? vv[cyc] : 1'b0;
            if (cyc < 7) begin a = av[cyc]; b = bv[cyc]; op = ov[cyc]; end
            @(negedge clk);
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL mac_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL mac_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (cyc == 0) model_acc = 16'h0000;
            if (vld && ready) exp_q.push_back(model(op, a, b, cyc == 3));
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mac_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Downstream stalls three cycles with two ops in flight; clear honoured while stalled.
    task automatic test_stall();
        logic [16:0] e;
        logic [15:0] held;
        for (int cyc = 0; cyc < 11; cyc++) begin
            rdy = !(cyc >= 2 && cyc <= 4);
            clr = (cyc == 3);
            case (cyc)
                0: begin vld = 1'b1; op = OP_ADD; a = 8'd1; b = 8'd2; end
                1: begin vld = 1'b1; op = OP_MUL; a = 8'd3; b = 8'd4; end
                2, 3, 4, 5: begin vld = 1'b1; op = OP_ADD; a = 8'd9; b = 8'd9; end
                6: begin vld = 1'b1; op = OP_MAC; a = 8'd2; b = 8'd3; end
                default: vld = 1'b0;
            endcase
            @(negedge clk);
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b, required 0", ready); end
                if (cyc == 2) held = res;
                else begin
                    checks++;
                    if (res !== held || res_valid !== 1'b1) begin
                        errors++; $display("FAIL stall_hold: got valid=%b res=%h, required valid=1 res=%h", res_valid, res, held);
                    end
                end
            end
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL stall_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (clr) model_acc = 16'h0000;
            if (vld && ready) exp_q.push_back(model(op, a, b, 1'b0));
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
        clr = 1'b0;
    endtask

    // Drive acc to 0xFFF0 then MAC (255,255): clamps with saturation, wraps without.
    task automatic test_mac_saturate();
        logic [7:0] av[6] = '{8'd0, 8'd255, 8'd15, 8'd255, 8'd0, 8'd255};
        logic [7:0] bv[6] = '{8'd0, 8'd255, 8'd33, 8'd255, 8'd5, 8'd255};
        logic [1:0] ov[6] = '{OP_MAC, OP_MAC, OP_MAC, OP_MAC, OP_MAC, OP_MUL};
        logic [16:0] e;
        for (int cyc = 0; cyc < 10; cyc++) begin
            rdy = 1'b1;
            clr = (cyc == 0);
            vld = (cyc >= 1 && cyc < 6);
            if (cyc < 6) begin a = av[cyc]; b = bv[cyc]; op = ov[cyc]; end
            @(negedge clk);
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sat_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL sat_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (cyc == 0) model_acc = 16'h0000;
            if (vld && ready) exp_q.push_back(model(op, a, b, 1'b0));
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sat_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Random ops with random upstream gaps and downstream back-pressure.
    task automatic test_back_to_back();
        logic [16:0] e;
        for (int cyc = 0; cyc < 90; cyc++) begin
            clr = 1'b0;
            if (cyc < 80) begin
                vld = ($urandom_range(0, 3) != 0);
                rdy = ($urandom_range(0, 3) != 0);
                a = 8'($urandom); b = 8'($urandom); op = 2'($urandom_range(0, 3));
            end else begin
                vld = 1'b0; rdy = 1'b1;
            end
            @(negedge clk);
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL b2b_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (vld && ready) exp_q.push_back(model(op, a, b, 1'b0));
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    // Reset pulsed mid-stream: outputs drop at once, in-flight ops vanish, acc restarts at 0.
    task automatic test_async_reset();
        logic [16:0] e;
        for (int cyc = 0; cyc < 3; cyc++) begin
            rdy = 1'b1; clr = 1'b0; vld = 1'b1;
            op = (cyc == 0) ? OP_MAC : OP_ADD; a = 8'd7; b = 8'd7;
            @(negedge clk);
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL arst_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL arst_pre_result: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (vld && ready) exp_q.push_back(model(op, a, b, 1'b0));
            @(posedge clk); #1;
        end
        vld = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, required 0", res_valid); end
        checks++;
        if (res !== 16'h0000 || sat !== 1'b0) begin errors++; $display("FAIL arst_result: got sat=%b res=%h, required sat=0 res=0000", sat, res); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b, required 1", ready); end
        exp_q.delete();
        model_acc = 16'h0000;
        @(posedge clk); @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            rdy = 1'b1; clr = 1'b0;
            vld = (cyc == 5); op = OP_MAC; a = 8'd1; b = 8'd1;
            @(negedge clk);
            if (cyc < 5) begin
                checks++;
                if (res_valid !== 1'b0) begin errors++; $display("FAIL arst_stale: got valid=%b res=%h, required valid=0", res_valid, res); end
            end
            if (res_valid && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL arst_extra: got result %h, required none", res);
                end else begin
                    e = exp_q.pop_front();
                    if ({sat, res} !== e) begin
                        errors++; $display("FAIL arst_acc: got sat=%b res=%h, required sat=%b res=%h", sat, res, e[16], e[15:0]);
                    end
                end
            end
            if (vld && ready) exp_q.push_back(model(op, a, b, 1'b0));
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL arst_lost: got %0d pending, required 0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sub_boundary();
        test_mac_clear();
        test_stall();
        test_mac_saturate();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "time limit");
    end

endmodule
